// File: rtl/riscv_run_checker.sv
// riscv_run_checker: runs one CPU program, then scans registers and a result window against expected values
module riscv_run_checker #(
  parameter int DATA_W    = 32,
  parameter int NUM_REGS  = 32,
  parameter int REG_AW    = 5,
  parameter int MEM_AW    = 10,
  parameter int RES_BASE  = 64,
  parameter int RES_WORDS = 3,
  parameter int TIMEOUT   = 700,
  parameter int CNT_W     = 16,
  parameter int IDX_W     = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              cpu_run,
  input  logic              cpu_done,
  input  logic [15:0]       clock_count,
  output logic [REG_AW-1:0] reg_addr,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [IDX_W-1:0]  exp_idx,
  input  logic [DATA_W-1:0] exp_data,
  output logic              busy,
  output logic              check_done,
  output logic              pass,
  output logic              timed_out,
  output logic [7:0]        err_count,
  output logic [IDX_W-1:0]  first_err_idx,
  output logic [CNT_W-1:0]  run_cycles,
  output logic [15:0]       cpu_cycles
);
  localparam int NB   = DATA_W / 8;
  localparam int TOT  = RES_WORDS * NB;
  localparam int MC_W = $clog2(TOT + 1);
  localparam int BW   = (NB > 1) ? $clog2(NB) : 1;
  typedef enum logic [2:0] {IDLE, RUN, REG_SCAN, MEM_SCAN, DONE} state_t;
  state_t state, state_nx;
  logic [IDX_W-1:0] rcnt, wcnt, nw, cmp_idx;
  logic [MC_W-1:0] mcnt;
  logic [BW-1:0] bcnt, nb;
  logic go, run_end, reg_end, issue, mem_end, last_byte, cmp_v, byte_v, mismatch;
  logic [DATA_W-1:0] sr, word, cmp_data;
  logic [DATA_W+7:0] cat;
  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  // next state, status outputs, byte assembly and compare
  always_comb begin
    go = start && (state == IDLE || state == DONE);
    run_end = state == RUN && (cpu_done || run_cycles == CNT_W'(TIMEOUT - 1));
    reg_end = state == REG_SCAN && rcnt == IDX_W'(NUM_REGS);
    issue = state == MEM_SCAN && mcnt < MC_W'(TOT);
    mem_end = state == MEM_SCAN && !issue;
    state_nx = go ? RUN : run_end ? REG_SCAN : reg_end ? MEM_SCAN : mem_end ? DONE : state;
    cpu_run = state == RUN;
    busy = state == RUN || state == REG_SCAN || state == MEM_SCAN;
    pass = state == DONE && err_count == 8'd0 && !timed_out;
    last_byte = bcnt == BW'(NB - 1);
    nb = last_byte ? '0 : bcnt + 1'b1;
    nw = last_byte ? wcnt + 1'b1 : wcnt;
    cat = {sr, mem_rdata};
    word = cat[DATA_W-1:0];
    cmp_data = state == MEM_SCAN ? word : reg_rdata;
    mismatch = cmp_v && cmp_data != exp_data;
  end
  // run timing, scan addressing and result accumulation
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      reg_addr <= '0;
      mem_addr <= '0;
      exp_idx <= '0;
      check_done <= 1'b0;
      timed_out <= 1'b0;
      err_count <= '0;
      first_err_idx <= '1;
      run_cycles <= '0;
      cpu_cycles <= '0;
      rcnt <= '0;
      wcnt <= '0;
      mcnt <= '0;
      bcnt <= '0;
      cmp_v <= 1'b0;
      cmp_idx <= '0;
      byte_v <= 1'b0;
      sr <= '0;
    end else begin
      check_done <= mem_end;
      cmp_v <= 1'b0;
      byte_v <= 1'b0;
      if (go) begin
        err_count <= '0;
        timed_out <= 1'b0;
        run_cycles <= '0;
        cpu_cycles <= '0;
        first_err_idx <= '1;
      end
      if (state == RUN) begin
        if (cpu_done) cpu_cycles <= clock_count;
        else begin
          run_cycles <= run_cycles + 1'b1;
          if (run_cycles == CNT_W'(TIMEOUT - 1)) timed_out <= 1'b1;
        end
      end
      if (run_end) begin
        rcnt <= '0;
        reg_addr <= '0;
        exp_idx <= '0;
      end
      if (state == REG_SCAN) begin
        rcnt <= rcnt + 1'b1;
        cmp_v <= rcnt < IDX_W'(NUM_REGS);
        cmp_idx <= rcnt;
        if (rcnt < IDX_W'(NUM_REGS - 1)) begin
          reg_addr <= REG_AW'(rcnt + 1'b1);
          exp_idx <= rcnt + 1'b1;
        end
      end
      if (reg_end) begin
        mcnt <= '0;
        bcnt <= '0;
        wcnt <= '0;
        mem_addr <= MEM_AW'(RES_BASE);
        if (NB == 1) exp_idx <= IDX_W'(NUM_REGS);
      end
      if (issue) begin
        mcnt <= mcnt + 1'b1;
        bcnt <= nb;
        wcnt <= nw;
        byte_v <= 1'b1;
        cmp_v <= last_byte;
        cmp_idx <= IDX_W'(NUM_REGS) + wcnt;
        if (mcnt < MC_W'(TOT - 1)) mem_addr <= mem_addr + 1'b1;
        if (nb == BW'(NB - 1) && mcnt < MC_W'(TOT - 1)) exp_idx <= IDX_W'(NUM_REGS) + nw;
      end
      if (byte_v) sr <= word;
      if (mismatch) begin
        if (err_count != 8'hFF) err_count <= err_count + 1'b1;
        if (first_err_idx == '1) first_err_idx <= cmp_idx;
      end
    end
  end
endmodule

// File: tb/tb_riscv_run_checker.sv
// tb_riscv_run_checker: directed vector bench with CPU, register file, memory and expected-value models
module tb_riscv_run_checker;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic cpu_run, cpu_done, busy, check_done, pass, timed_out;
  logic [15:0] clock_count = 16'd118;
  logic [4:0] reg_addr;
  logic [31:0] reg_rdata, exp_data;
  logic [9:0] mem_addr;
  logic [7:0] mem_rdata, err_count;
  logic [5:0] exp_idx, first_err_idx;
  logic [15:0] run_cycles, cpu_cycles;
  logic [31:0] regs [32];
  logic [7:0] mem [1024];
  logic [31:0] expv [64];
  int done_at = 120;
  int cnt = 0, pulses = 0, run_hi = 0, scan_cyc = 0;
  int ntot = 0, npass = 0;
  typedef struct {
    int done_at;
    bit bad_reg, bad_w1, swap_w0;
    int run, cpu, err, first, hi;
    bit pass, timed;
  } vec_t;
  vec_t vecs [5];
  riscv_run_checker dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cpu_run(cpu_run), .cpu_done(cpu_done),
    .clock_count(clock_count), .reg_addr(reg_addr), .reg_rdata(reg_rdata),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .exp_idx(exp_idx), .exp_data(exp_data),
    .busy(busy), .check_done(check_done), .pass(pass), .timed_out(timed_out),
    .err_count(err_count), .first_err_idx(first_err_idx), .run_cycles(run_cycles),
    .cpu_cycles(cpu_cycles)
  );
  always #5 clk = ~clk;
  assign cpu_done = cpu_run && done_at >= 0 && cnt == done_at;
  always_ff @(posedge clk) begin
    cnt <= cpu_run ? cnt + 1 : 0;
    reg_rdata <= regs[reg_addr];
    mem_rdata <= mem[mem_addr];
    exp_data <= expv[exp_idx];
    if (check_done) pulses <= pulses + 1;
    if (cpu_run) run_hi <= run_hi + 1;
    if (busy && !cpu_run) scan_cyc <= scan_cyc + 1;
  end
  task automatic chk(input string name, input longint act, input longint req);
    ntot++;
    if (act == req) npass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, req);
  endtask
  task automatic setup(input vec_t v);
    done_at = v.done_at;
    for (int i = 0; i < 32; i++) begin
      regs[i] = 32'h1000_0000 + i * 32'h0101;
      expv[i] = regs[i];
    end
    for (int i = 0; i < 1024; i++) mem[i] = 8'hEE;
    {mem[64], mem[65], mem[66], mem[67]} = 32'h12345678;
    {mem[68], mem[69], mem[70], mem[71]} = 32'h9ABCDEF0;
    {mem[72], mem[73], mem[74], mem[75]} = 32'h01020304;
    expv[32] = v.swap_w0 ? 32'h78563412 : 32'h12345678;
    expv[33] = v.bad_w1 ? 32'h9ABCDEF1 : 32'h9ABCDEF0;
    expv[34] = 32'h01020304;
    if (v.bad_reg) begin
      regs[11] = 32'h0000002A;
      expv[11] = 32'h0000002B;
    end
  endtask
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 3000 && !ok; k++) begin
      @(negedge clk);
      if (check_done) ok = 1'b1;
    end
    if (!ok) chk("check_done_timeout", 0, 1);
  endtask
  task automatic run_vec(input vec_t v, input string tag);
    int p0, h0, s0;
    bit ok;
    setup(v);
    p0 = pulses;
    h0 = run_hi;
    s0 = scan_cyc;
    pulse_start();
    wait_done(ok);
    if (ok) begin
      chk({tag, " run_cycles"}, run_cycles, v.run);
      chk({tag, " cpu_cycles"}, cpu_cycles, v.cpu);
      chk({tag, " err_count"}, err_count, v.err);
      chk({tag, " first_err_idx"}, first_err_idx, v.first);
      chk({tag, " pass"}, pass, v.pass);
      chk({tag, " timed_out"}, timed_out, v.timed);
      chk({tag, " cpu_run_cycles"}, run_hi - h0, v.hi);
      chk({tag, " scan_cycles"}, scan_cyc - s0, 46);
      chk({tag, " busy_in_done"}, busy, 0);
      chk({tag, " reg_addr_hold"}, reg_addr, 31);
      chk({tag, " mem_addr_hold"}, mem_addr, 75);
      chk({tag, " exp_idx_hold"}, exp_idx, 34);
      repeat (3) @(negedge clk);
      chk({tag, " one_pulse"}, pulses - p0, 1);
      chk({tag, " pass_held"}, pass, v.pass);
    end
  endtask
  initial begin
    int p0, s0;
    bit ok;
    vecs[0] = '{120, 0, 0, 0, 120, 118, 0, 63, 121, 1, 0};
    vecs[1] = '{120, 1, 1, 0, 120, 118, 2, 11, 121, 0, 0};
    vecs[2] = '{-1, 0, 0, 0, 700, 0, 0, 63, 700, 0, 1};
    vecs[3] = '{120, 0, 0, 1, 120, 118, 1, 32, 121, 0, 0};
    vecs[4] = '{0, 0, 0, 0, 0, 118, 0, 63, 1, 1, 0};
    setup(vecs[0]);
    repeat (3) @(negedge clk);
    chk("rst busy", busy, 0);
    chk("rst cpu_run", cpu_run, 0);
    chk("rst err_count", err_count, 0);
    chk("rst first_err_idx", first_err_idx, 63);
    chk("rst run_cycles", run_cycles, 0);
    chk("rst check_done", check_done, 0);
    chk("rst pass", pass, 0);
    chk("rst mem_addr", mem_addr, 0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));
    run_vec(vecs[1], "pre_restart");
    pulse_start();
    chk("restart err_count", err_count, 0);
    chk("restart first_err_idx", first_err_idx, 63);
    chk("restart run_cycles", run_cycles, 0);
    chk("restart cpu_cycles", cpu_cycles, 0);
    chk("restart busy", busy, 1);
    wait_done(ok);
    if (ok) chk("restart err_final", err_count, 2);
    setup(vecs[0]);
    p0 = pulses;
    s0 = scan_cyc;
    pulse_start();
    for (int k = 0; k < 2000 && cpu_run; k++) @(negedge clk);
    repeat (5) @(negedge clk);
    pulse_start();
    wait_done(ok);
    if (ok) begin
      chk("busy_start err_count", err_count, 0);
      chk("busy_start pass", pass, 1);
      chk("busy_start scan_cycles", scan_cyc - s0, 46);
      chk("busy_start pulses", pulses - p0, 1);
    end
    setup(vecs[1]);
    pulse_start();
    ok = 1'b0;
    for (int k = 0; k < 2000 && !ok; k++) begin
      @(negedge clk);
      if (mem_addr == 10'd64) ok = 1'b1;
    end
    chk("mem_scan_reached", ok, 1);
    @(negedge clk);
    chk("mid_mem err_before_rst", err_count, 1);
    p0 = pulses;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst busy", busy, 0);
    chk("mid_rst err_count", err_count, 0);
    chk("mid_rst first_err_idx", first_err_idx, 63);
    chk("mid_rst mem_addr", mem_addr, 0);
    repeat (60) @(negedge clk);
    chk("mid_rst no_pulse", pulses - p0, 0);
    chk("mid_rst still_idle", busy, 0);
    run_vec(vecs[0], "after_rst");
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
